evm_vote_counter: RTL and testbench
===================================

# evm_vote_counter

Ballot-side tally stage of the EVM datapath. Accepts raw candidate push-buttons, enforces one vote per presiding-officer ballot enable, and keeps four saturating 4-bit tallies. The tallies are the four data inputs of the downstream 4:1 result selector. During result display, the block also drives that selector's 2-bit select.

## Interface
Parameters:
- CNT_W, 4: tally width per candidate; must match the selector data width.
- SCAN_DIV, 8: clocks per candidate slot in auto-scan (only used with EVM_SCAN_EN); must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- ballot_en  in  1  single-cycle pulse from the presiding officer; arms one vote.
- cand_btn  in  4  raw, asynchronous candidate buttons; bit i = candidate i.
- result_mode  in  1  level; request to show results.
- result_next  in  1  single-cycle pulse; advance displayed candidate (manual scan only).
- count_a, count_b, count_c, count_d  out  CNT_W each  tallies for candidates 0–3; feed selector inputs A–D.
- sel  out  2  selector select during result display.
- ready  out  1  high while armed and waiting for a vote.
- vote_ack  out  1  one-cycle pulse when a vote is registered.
- invalid  out  1  one-cycle pulse when an armed press is rejected.
- overflow  out  1  sticky; set when any vote hits a saturated tally.

## Operation
- Input conditioning: each cand_btn bit passes through a 2-flop synchronizer. A press is a rising edge of the synchronized vector (s2 & ~s2_d).
- FSM states: IDLE, ARMED, WAIT_REL, RESULT.
- **IDLE**
  - ballot_en=1 → ARMED.
  - Otherwise, result_mode=1 → RESULT.
  - If both are high, ballot_en wins.
- **ARMED**
  - ready=1. ballot_en and result_mode are ignored.
  - Press with exactly one bit set → that tally increments, vote_ack=1 → WAIT_REL.
  - Press with more than one bit set, or any press edge while another synchronized button is already held → invalid=1, no tally change. Stay ARMED.
- **WAIT_REL**: remain until the synchronized vector is all zero, then → IDLE. This prevents a held button from carrying into the next ballot.
- **RESULT**
  - Button presses and ballot_en are ignored.
  - result_mode=0 → IDLE with sel reset to 0.
  - sel advances 0→1→2→3→0 according to the scan rule in Configuration.
- Arithmetic: a tally at 2^CNT_W−1 (15) holds that value on a further vote. vote_ack still pulses and overflow is set. Tallies never wrap.
- overflow clears only on reset.
- Outside RESULT, sel holds 0.

## Timing
- Reset values: all tallies 0, sel 0, ready 0, vote_ack 0, invalid 0, overflow 0, FSM IDLE, synchronizer flops 0.
- Reset mid-vote clears every tally. Recording and result display are not preserved across reset.
- Vote latency:
  - Button stable high before edge e0. s1 is high after e0; s2 is high after e1.
  - At e2: tally, vote_ack and the WAIT_REL transition all register together.
  - ready drops at e2.
- ARMED → ready is high from the edge after the ballot_en edge.
- vote_ack and invalid are exactly one cycle wide and never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: EVM_SCAN_EN.
- **Defined**: in RESULT, a counter divides by SCAN_DIV. sel advances every SCAN_DIV clocks, starting at 0 on RESULT entry. result_next is ignored.
- **Undefined**: no divider is built. sel advances by one on each result_next pulse seen in RESULT, wrapping 3→0.

## Structure
- Shared package evm_pkg:
  - FSM state enum (IDLE, ARMED, WAIT_REL, RESULT).
  - NUM_CAND=4 and CNT_W default.
  - SCAN_DIV default.
- Sub-module evm_btn_sync:
  - 2-flop synchronizer plus registered delay and rising-edge output for a 4-bit vector.
  - Synchronous active-low reset.
  - One instance.

## Test plan
- Reset, then ballot_en; hold cand_btn=4'b0010 for 5 cycles → count_b=1 at the 3rd edge after the press. vote_ack pulses once; other tallies stay 0.
- Armed, press 4'b0101 → invalid pulse and no tally change. Release, then press 4'b1000 → count_d=1.
- Press cand_btn=4'b0001 with no ballot_en → no change. Vote, keep the button held, pulse ballot_en again → no second vote until release and re-press.
- Sixteen ballots for candidate 0 → count_a=15 and overflow=1 after the 16th; count_a stays 15.
- result_mode=1 from IDLE with tallies A=3, B=1:
  - EVM_SCAN_EN: sel steps 0,1,2,3,0 every 8 clocks.
  - Without it: each result_next pulse advances sel.
  - result_mode=0 → sel=0.
- Assert rst_n=0 for one edge mid-RESULT with nonzero tallies → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/evm_pkg.sv
// evm_pkg: shared types and defaults for the EVM ballot tally stage.
// Optional build macro used by this slice: EVM_SCAN_EN (auto-scan results).
package evm_pkg;

  localparam int NUM_CAND     = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int SCAN_DIV_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_REL,
    RESULT
  } state_t;

  function automatic logic one_hot(
    input logic [NUM_CAND-1:0] v
  );
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/evm_btn_sync.sv
// evm_btn_sync: 2-flop synchronizer with delayed copy and rising-edge detect.
// Synchronous active-low reset; part of evm_vote_counter (macro EVM_SCAN_EN unused here).
module evm_btn_sync
  import evm_pkg::*;
#(
  parameter int W = NUM_CAND
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s2_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s2_d <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/evm_vote_counter.sv
// evm_vote_counter: one-vote-per-ballot tally stage with result select drive.
// Build macro EVM_SCAN_EN: auto-scan sel every SCAN_DIV clocks instead of result_next.
module evm_vote_counter
  import evm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ballot_en,
  input  logic [3:0]       cand_btn,
  input  logic             result_mode,
  input  logic             result_next,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [CNT_W-1:0] count_c,
  output logic [CNT_W-1:0] count_d,
  output logic [1:0]       sel,
  output logic             ready,
  output logic             vote_ack,
  output logic             invalid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt [NUM_CAND];
  logic [1:0]                r_sel;
  logic                      r_ready;
  logic                      r_ack;
  logic                      r_inv;
  logic                      r_ovf;
  logic [NUM_CAND-1:0]       w_sync;
  logic [NUM_CAND-1:0]       w_rise;
  logic [NUM_CAND-1:0]       w_held;
  logic                      w_good;

`ifdef EVM_SCAN_EN
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  logic [DIV_W-1:0] r_div;
`endif

  evm_btn_sync #(
    .W (NUM_CAND)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (cand_btn),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  // A new edge is only a vote if nothing else is already held down.
  assign w_held = w_sync & ~w_rise;
  assign w_good = one_hot(w_rise) && (w_held == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
      r_inv   <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
`ifdef EVM_SCAN_EN
      r_div   <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_inv <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (ballot_en) begin
            r_state <= ARMED;
            r_ready <= 1'b1;
          end else if (result_mode) begin
            r_state <= RESULT;
            r_sel   <= '0;
`ifdef EVM_SCAN_EN
            r_div   <= '0;
`endif
          end
        end
        ARMED: begin
          if (w_rise != '0) begin
            if (w_good) begin
              for (int i = 0; i < NUM_CAND; i++) begin
                if (w_rise[i]) begin
                  if (r_cnt[i] == CNT_MAX) r_ovf <= 1'b1;
                  else r_cnt[i] <= r_cnt[i] + 1'b1;
                end
              end
              r_ack   <= 1'b1;
              r_ready <= 1'b0;
              r_state <= WAIT_REL;
            end else begin
              r_inv <= 1'b1;
            end
          end
        end
        WAIT_REL: begin
          if (w_sync == '0) r_state <= IDLE;
        end
        RESULT: begin
          if (!result_mode) begin
            r_state <= IDLE;
            r_sel   <= '0;
          end else begin
`ifdef EVM_SCAN_EN
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              r_sel <= r_sel + 1'b1;
            end else begin
              r_div <= r_div + 1'b1;
            end
`else
            if (result_next) r_sel <= r_sel + 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count_a  = r_cnt[0];
  assign count_b  = r_cnt[1];
  assign count_c  = r_cnt[2];
  assign count_d  = r_cnt[3];
  assign sel      = r_sel;
  assign ready    = r_ready;
  assign vote_ack = r_ack;
  assign invalid  = r_inv;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_evm_vote_counter.sv
// tb_evm_vote_counter: directed + random ballots against a ballot-level model.
// Honours EVM_SCAN_EN for the result display section.
module tb_evm_vote_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ballot_en;
  logic [3:0] cand_btn;
  logic       result_mode;
  logic       result_next;
  logic [3:0] count_a, count_b, count_c, count_d;
  logic [1:0] sel;
  logic       ready, vote_ack, invalid, overflow;

  int checks = 0;
  int errors = 0;
  int n_ack;
  int n_inv;
  int m_cnt [4];
  bit m_ovf;

  evm_vote_counter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ballot_en   (ballot_en),
    .cand_btn    (cand_btn),
    .result_mode (result_mode),
    .result_next (result_next),
    .count_a     (count_a),
    .count_b     (count_b),
    .count_c     (count_c),
    .count_d     (count_d),
    .sel         (sel),
    .ready       (ready),
    .vote_ack    (vote_ack),
    .invalid     (invalid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_ack += int'(vote_ack);
      n_inv += int'(invalid);
      if (vote_ack && invalid) chk("ack_inv_excl", 32'd1, 32'd0);
    end
  endtask

  task automatic model_vote(input int c);
    if (m_cnt[c] == 15) m_ovf = 1'b1;
    else m_cnt[c]++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a"}, count_a, m_cnt[0]);
    chk({tag, "_b"}, count_b, m_cnt[1]);
    chk({tag, "_c"}, count_c, m_cnt[2]);
    chk({tag, "_d"}, count_d, m_cnt[3]);
    chk({tag, "_ovf"}, overflow, m_ovf);
  endtask

  task automatic arm();
    ballot_en = 1'b1;
    run(1);
    ballot_en = 1'b0;
    chk("ready_on_arm", ready, 1);
  endtask

  task automatic idx_of(input logic [3:0] b, output int c);
    c = 0;
    for (int i = 0; i < 4; i++) if (b[i]) c = i;
  endtask

  task automatic vote(input logic [3:0] b);
    int c;
    arm();
    n_ack = 0; n_inv = 0;
    cand_btn = b;
    run(5);
    cand_btn = 4'b0;
    run(4);
    idx_of(b, c);
    model_vote(c);
    chk("vote_ack_cnt", n_ack, 1);
    chk("vote_inv_cnt", n_inv, 0);
  endtask

  task automatic vote_bad(input logic [3:0] bad, input logic [3:0] good);
    int c;
    arm();
    n_ack = 0; n_inv = 0;
    cand_btn = bad;
    run(5);
    chk("bad_ready_kept", ready, 1);
    cand_btn = 4'b0;
    run(3);
    cand_btn = good;
    run(5);
    cand_btn = 4'b0;
    run(4);
    idx_of(good, c);
    model_vote(c);
    chk("bad_ack_cnt", n_ack, 1);
    chk("bad_inv_cnt", n_inv, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [3:0] b;
    int c;
    rst_n = 1'b0; ballot_en = 1'b0; cand_btn = 4'b0;
    result_mode = 1'b0; result_next = 1'b0;
    n_ack = 0; n_inv = 0;
    do_reset();
    chk_model("rst");
    chk("rst_sel", sel, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ack", vote_ack, 0);
    chk("rst_inv", invalid, 0);

    // single vote, exact latency
    arm();
    cand_btn = 4'b0010;
    n_ack = 0;
    run(2);
    chk("lat_e1_b", count_b, 0);
    run(1);
    chk("lat_e2_b", count_b, 1);
    chk("lat_e2_ack", vote_ack, 1);
    chk("lat_e2_ready", ready, 0);
    run(1);
    chk("lat_ack_1cyc", vote_ack, 0);
    run(1);
    cand_btn = 4'b0;
    run(4);
    chk("lat_ack_once", n_ack, 1);
    m_cnt[1] = 1;
    chk_model("t1");

    // multi-press rejected, then valid vote for d
    vote_bad(4'b0101, 4'b1000);
    chk_model("t2");

    // press with no ballot, then held button across a new ballot
    n_ack = 0;
    cand_btn = 4'b0001;
    run(5);
    cand_btn = 4'b0;
    run(4);
    chk("noballot_ack", n_ack, 0);
    chk_model("t3a");
    arm();
    cand_btn = 4'b0001;
    run(5);
    model_vote(0);
    ballot_en = 1'b1;
    run(1);
    ballot_en = 1'b0;
    run(3);
    chk("held_ready", ready, 0);
    chk("held_ack", n_ack, 1);
    cand_btn = 4'b0;
    run(4);
    cand_btn = 4'b0001;
    run(5);
    cand_btn = 4'b0;
    run(4);
    chk("repress_ack", n_ack, 1);
    chk_model("t3b");
    vote(4'b0001);
    chk_model("t3c");

    // random ballots
    repeat (10) begin
      b = 4'($urandom_range(1, 15));
      if ($countones(b) == 1) vote(b);
      else begin
        c = $urandom_range(0, 3);
        vote_bad(b, 4'(1 << c));
      end
      chk_model("rnd");
    end

    // saturation of candidate 0
    repeat (16) vote(4'b0001);
    chk_model("sat");
    chk("sat_a15", count_a, 15);
    chk("sat_ovf", overflow, 1);
    vote(4'b0001);
    chk("sat_hold", count_a, 15);

    // result display with A=3, B=1
    do_reset();
    chk_model("rst2");
    repeat (3) vote(4'b0001);
    vote(4'b0010);
    chk_model("res_tally");
    result_mode = 1'b1;
    run(1);
    chk("res_sel0", sel, 0);
`ifdef EVM_SCAN_EN
    result_next = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      run(7);
      chk("scan_hold", sel, (k - 1) % 4);
      run(1);
      chk("scan_step", sel, k % 4);
    end
    result_next = 1'b0;
    run(8);
`else
    for (int k = 1; k <= 4; k++) begin
      result_next = 1'b1;
      run(1);
      result_next = 1'b0;
      chk("man_step", sel, k % 4);
      run(2);
      chk("man_hold", sel, k % 4);
    end
    result_next = 1'b1;
    run(1);
    result_next = 1'b0;
`endif
    chk("res_sel1", sel, 1);
    ballot_en = 1'b1;
    cand_btn = 4'b0100;
    run(1);
    ballot_en = 1'b0;
    run(4);
    chk("res_ignore_ballot", ready, 0);
    cand_btn = 4'b0;
    run(3);
    chk_model("res_ignore_btn");
    result_mode = 1'b0;
    run(1);
    chk("res_exit_sel", sel, 0);

    // reset in the middle of RESULT
    result_mode = 1'b1;
    run(1);
`ifdef EVM_SCAN_EN
    run(8);
`else
    result_next = 1'b1;
    run(1);
    result_next = 1'b0;
`endif
    chk("pre_rst_sel", sel, 1);
    rst_n = 1'b0;
    result_mode = 1'b0;
    run(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ovf = 1'b0;
    chk_model("mid_rst");
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_ack", vote_ack, 0);
    chk("mid_rst_inv", invalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
